// File: rtl/noc_pkg.sv
// Shared NoC definitions: port numbering, the "no grant" select code and the
// per-output lock state used by the switch allocator.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_N    = 3'd0;
    localparam logic [2:0] PORT_S    = 3'd1;
    localparam logic [2:0] PORT_E    = 3'd2;
    localparam logic [2:0] PORT_W    = 3'd3;
    localparam logic [2:0] PORT_L    = 3'd4;
    localparam logic [2:0] PORT_NONE = 3'b111;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_lock_arb.sv
// One output's arbiter: round-robin search among requesting inputs, then holds
// the output for the winner until its tail flit goes through (wormhole lock).
module rr_lock_arb #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 full,
    output logic                 grant,
    output logic [2:0]           winner
);

    noc_pkg::lock_state_t state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic       search_hit;
    logic [2:0] search_win;

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (int'(p) == NUM_PORTS - 1) ? 3'd0 : p + 3'd1;
    endfunction

    // Walk from the highest offset down so the closest requester to ptr wins.
    function automatic logic [3:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                           input logic [2:0] p);
        logic [3:0] res;
        int         idx;
        res = {1'b0, noc_pkg::PORT_NONE};
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (r[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        {search_hit, search_win} = rr_pick(req, ptr_q);
    end

    always_comb begin
        grant   = 1'b0;
        winner  = noc_pkg::PORT_NONE;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (!full) begin
            case (state_q)
                noc_pkg::LOCK_IDLE: begin
                    if (search_hit) begin
                        grant  = 1'b1;
                        winner = search_win;
                        if (tail[search_win]) begin
                            ptr_d = next_port(search_win);
                        end else begin
                            state_d = noc_pkg::LOCK_LOCKED;
                            owner_d = search_win;
                        end
                    end
                end
                noc_pkg::LOCK_LOCKED: begin
                    if (req[owner_q]) begin
                        grant  = 1'b1;
                        winner = owner_q;
                        if (tail[owner_q]) begin
                            state_d = noc_pkg::LOCK_IDLE;
                            ptr_d   = next_port(owner_q);
                        end
                    end
                end
                default: state_d = noc_pkg::LOCK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= noc_pkg::LOCK_IDLE;
            owner_q <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: one lock/round-robin arbiter per output, combinational
// grants, crossbar selects and FIFO pops, plus a sticky bad-port error flag.
module switch_allocator #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_valid_i,
    input  logic [3*NUM_PORTS-1:0] req_port_i,
    input  logic [NUM_PORTS-1:0]   req_tail_i,
    input  logic [NUM_PORTS-1:0]   out_full_i,
    output logic [3*NUM_PORTS-1:0] grant_sel_o,
    output logic [NUM_PORTS-1:0]   out_en_o,
    output logic [NUM_PORTS-1:0]   in_pop_o,
    output logic                   err_o
);

    logic [NUM_PORTS-1:0] req_mat [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_grant;
    logic [2:0]           arb_winner [NUM_PORTS];
    logic                 bad_req;

    // Codes at or above NUM_PORTS match no output, so they are never granted.
    always_comb begin
        bad_req = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_mat[o][i] = req_valid_i[i] && (int'(req_port_i[3*i +: 3]) == o);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_valid_i[i] && (int'(req_port_i[3*i +: 3]) >= NUM_PORTS)) bad_req = 1'b1;
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        rr_lock_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (req_mat[o]),
            .tail   (req_tail_i),
            .full   (out_full_i[o]),
            .grant  (arb_grant[o]),
            .winner (arb_winner[o])
        );
    end

    // Grants are combinational, so they are masked while reset is held.
    always_comb begin
        grant_sel_o = '1;
        out_en_o    = '0;
        in_pop_o    = '0;
        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (arb_grant[o]) begin
                    grant_sel_o[3*o +: 3] = arb_winner[o];
                    out_en_o[o]           = 1'b1;
                    in_pop_o[arb_winner[o]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (bad_req) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of router ports (N=0, S=1, E=2, W=3, L=4).
REQ-002 SHALL have port clk  input  1  router clock, single clock domain.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  5  per-input head-of-FIFO flit valid.
REQ-005 SHALL have port req_port_i  input  15  per-input requested output, 3 bits per input, input i at [3i+2:3i].
REQ-006 SHALL have port req_tail_i  input  5  per-input flag: current flit is the last flit of its packet.
REQ-007 SHALL have port out_full_i  input  5  per-output flag: no downstream credit.
REQ-008 SHALL have port grant_sel_o  output  15  per-output crossbar select, 3 bits per output; 3'b111 means none.
REQ-009 SHALL have port out_en_o  output  5  per-output send strobe.
REQ-010 SHALL have port in_pop_o  output  5  per-input FIFO pop strobe.
REQ-011 SHALL have port err_o  output  1  sticky flag: a valid request named port code 5..7.

Function
REQ-012 SHALL compute grants combinationally from the current inputs and registered state, with zero-cycle latency; state SHALL update on the rising edge of clk.
REQ-013 SHALL keep, per output, a round-robin pointer ptr (0..4) and a lock state machine with states IDLE and LOCKED(owner).
REQ-014 In IDLE with out_full_i low, SHALL grant the first valid input requesting that output, searching ptr, ptr+1, ... modulo 5.
REQ-015 On an IDLE grant of a non-tail flit, SHALL move to LOCKED(winner), leaving ptr unchanged.
REQ-016 On an IDLE grant of a tail flit (single-flit packet), SHALL stay IDLE and set ptr to (winner+1) mod 5.
REQ-017 In LOCKED(owner), SHALL consider only input owner; other requesters for that output SHALL be ignored.
REQ-018 In LOCKED(owner), when the owner's tail flit is granted, SHALL return to IDLE and set ptr to (owner+1) mod 5.
REQ-019 While out_full_i is high, SHALL issue no grant on that output and SHALL hold lock state and ptr.
REQ-020 For each granted output o with winner i, SHALL drive grant_sel_o[o]=i, out_en_o[o]=1 and in_pop_o[i]=1 in the same cycle.
REQ-021 Non-granted outputs SHALL drive grant_sel_o=3'b111 and out_en_o=0.
REQ-022 SHALL assert in_pop_o[i] at most once per cycle; at most one output can grant a given input, because each input names one output.
REQ-023 A request with port code 5..7 SHALL never be granted and SHALL set err_o, which stays set until reset.
REQ-024 U-turn requests (requested output equals the input port) SHALL be arbitrated like any other request.

Reset
REQ-025 While rst is high, SHALL force all outputs idle: grant_sel_o all 3'b111, out_en_o=0, in_pop_o=0, err_o=0.
REQ-026 Reset SHALL set every ptr to 0 and every lock state to IDLE, including on assertion mid-packet.
REQ-027 After rst deasserts, the first grant SHALL be possible in the same cycle that a request is presented.

Structure
REQ-028 Shared package noc_pkg SHALL hold NUM_PORTS, the port index constants N/S/E/W/L, PORT_NONE=3'b111, and the lock-state typedef.
REQ-029 SHALL instantiate one sub-module rr_lock_arb per output; each instance contains one ptr, the lock FSM, and the 5-way priority search.

Verification
REQ-030 Single flit: N requests E with tail=1 and E not full -> same cycle grant_sel E=0, out_en E=1, in_pop N=1; next cycle E ptr=1.
REQ-031 Contention: S, W and L all request L with single-flit packets, held valid for 3 cycles, ptr=0 -> grants occur in order S, W, L, one per cycle.
REQ-032 Wormhole: N sends a 3-flit packet to E while S also requests E -> E grants N for 3 consecutive cycles, S is blocked, then S is granted on cycle 4.
REQ-033 Backpressure: out_full_i[E] is high for 2 cycles in the middle of a locked packet -> no out_en E and no pop during those cycles; the lock is kept and resumes with the same owner.
REQ-034 Reset mid-packet: rst is asserted while E is LOCKED(N) -> outputs go idle immediately; after release, E is IDLE with ptr=0 and a W request is granted.
REQ-035 Bad port: L requests port code 6 -> never popped, err_o=1 from the next edge, and err_o stays 1 until rst.
